keypad_loader: RTL and testbench

Front end that drives the microwave countdown timer's digit-load interface from a 10-key numeric keypad plus start/cancel buttons. Debounces and encodes key presses to BCD and pulses loadn low once per accepted digit so the timer shifts it in (sec_ones ← data, earlier digits move up). Sequences entry, run, pause and done. Consumes the timer's zero flag to end a cook cycle.

---
 rtl/microwave_pkg.sv | 31 +++
 rtl/key_debounce.sv | 62 ++++++
 rtl/keypad_loader.sv | 119 +++++++++++
 tb/tb_keypad_loader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave keypad front end.
// Holds the sequencer state encoding and the keypad decode helpers.
package microwave_pkg;

  localparam int unsigned KEY_W               = 10;
  localparam int unsigned BCD_W               = 4;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;

  typedef enum logic [2:0] {
    StIdle,
    StEntry,
    StRun,
    StPause,
    StDone
  } state_e;

  // Index of the highest set key; callers guarantee a one-hot input.
  function automatic logic [BCD_W-1:0] key_to_bcd(input logic [KEY_W-1:0] k);
    logic [BCD_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < KEY_W; i++) begin
      if (k[i]) idx = BCD_W'(i);
    end
    return idx;
  endfunction

  function automatic logic multi_hot(input logic [KEY_W-1:0] k);
    return (k & (k - KEY_W'(1))) != '0;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Keypad debouncer: waits for a stable sample run, then emits one digit
// pulse per press (or an error pulse for chords) and re-arms on stable release.
module key_debounce
  import microwave_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [KEY_W-1:0] keys,
  output logic             key_valid,
  output logic [BCD_W-1:0] key_bcd,
  output logic             key_err
);

  localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [KEY_W-1:0] samp_q;
  logic [CNT_W-1:0] cnt_q;
  logic             armed_q;
  logic             stable_hit;

  // True only on the edge where the counter reaches CNT_MAX.
  assign stable_hit = (keys == samp_q) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (clr) begin
      samp_q    <= '0;
      cnt_q     <= '0;
      armed_q   <= 1'b1;
      key_valid <= 1'b0;
      key_bcd   <= '0;
      key_err   <= 1'b0;
    end else begin
      samp_q    <= keys;
      key_valid <= 1'b0;
      key_err   <= 1'b0;

      if (keys != samp_q) begin
        cnt_q <= '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      if (stable_hit) begin
        if (keys == '0) begin
          armed_q <= 1'b1;
        end else if (multi_hot(keys)) begin
          key_err <= 1'b1;
          armed_q <= 1'b0;
        end else if (armed_q) begin
          key_valid <= 1'b1;
          key_bcd   <= key_to_bcd(keys);
          armed_q   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/keypad_loader.sv
// Keypad-to-timer loader: shifts debounced digits into the countdown timer
// and sequences entry, run, pause and done around start/cancel/zero.
module keypad_loader
  import microwave_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned MAX_DIGITS      = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [KEY_W-1:0] keys,
  input  logic             start,
  input  logic             cancel,
  input  logic             zero,
  output logic [BCD_W-1:0] data,
  output logic             loadn,
  output logic             en,
  output logic             tclrn,
  output logic [1:0]       digit_cnt,
  output logic             err
);

  localparam logic [1:0] MAX_CNT = 2'(MAX_DIGITS);

  state_e           state_q;
  logic             key_valid;
  logic [BCD_W-1:0] key_bcd;
  logic             key_err;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .clr       (clr),
    .keys      (keys),
    .key_valid (key_valid),
    .key_bcd   (key_bcd),
    .key_err   (key_err)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= StIdle;
      data      <= '0;
      loadn     <= 1'b1;
      en        <= 1'b0;
      tclrn     <= 1'b1;
      digit_cnt <= '0;
      err       <= 1'b0;
    end else begin
      loadn <= 1'b1;
      tclrn <= 1'b1;
      err   <= key_err;

      unique case (state_q)
        StIdle: begin
          if (cancel) begin
            tclrn <= 1'b0;
          end else if (key_valid) begin
            data      <= key_bcd;
            loadn     <= 1'b0;
            digit_cnt <= 2'd1;
            state_q   <= StEntry;
          end
        end
        StEntry: begin
          if (cancel) begin
            tclrn     <= 1'b0;
            digit_cnt <= '0;
            state_q   <= StIdle;
          end else if (start) begin
            en      <= 1'b1;
            state_q <= StRun;
          end else if (key_valid) begin
            if (digit_cnt < MAX_CNT) begin
              data      <= key_bcd;
              loadn     <= 1'b0;
              digit_cnt <= digit_cnt + 2'd1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        StRun: begin
          // zero outranks cancel so a finished cook never lands in pause
          if (zero) begin
            en      <= 1'b0;
            state_q <= StDone;
          end else if (cancel) begin
            en      <= 1'b0;
            state_q <= StPause;
          end
        end
        StPause: begin
          if (cancel) begin
            tclrn     <= 1'b0;
            digit_cnt <= '0;
            state_q   <= StIdle;
          end else if (start) begin
            en      <= 1'b1;
            state_q <= StRun;
          end
        end
        StDone: begin
          if (key_valid || start || cancel) begin
            tclrn     <= 1'b0;
            digit_cnt <= '0;
            state_q   <= StIdle;
          end
        end
        default: begin
          en      <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_loader.sv
// Scoreboard bench for keypad_loader: a cycle model pushes expected strobes,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_keypad_loader;

  localparam int D    = 4;
  localparam int MAXD = 3;

  logic       clk = 1'b0;
  logic       clr, start, cancel, zero;
  logic [9:0] keys;
  logic [3:0] data;
  logic       loadn, en, tclrn, err;
  logic [1:0] digit_cnt;

  always #5 clk = ~clk;

  keypad_loader #(
    .DEBOUNCE_CYCLES(D),
    .MAX_DIGITS     (MAXD)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .keys      (keys),
    .start     (start),
    .cancel    (cancel),
    .zero      (zero),
    .data      (data),
    .loadn     (loadn),
    .en        (en),
    .tclrn     (tclrn),
    .digit_cnt (digit_cnt),
    .err       (err)
  );

  // kind: 0 = load strobe, 1 = timer clear strobe, 2 = error pulse
  typedef struct {
    int kind;
    int val;
  } ev_t;
  ev_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int n_loads = 0;
  int n_errs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {MIdle, MEntry, MRun, MPause, MDone} mst_e;
  mst_e       m_st;
  logic [9:0] m_last;
  int         m_run, m_pend, m_pbcd, m_cnt, m_data;
  bit         m_armed, m_en, m_ready = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (clr) begin
        m_last = '0; m_run = 1; m_armed = 1; m_pend = 0; m_pbcd = 0;
        m_st = MIdle; m_cnt = 0; m_en = 0; m_data = 0;
        exp_q.delete();
        m_ready = 1;
      end else if (m_ready) begin
        bit kv, ld, tc, er;
        kv = (m_pend == 1);
        er = (m_pend == 2);
        ld = 0; tc = 0;
        case (m_st)
          MIdle:  if (cancel) tc = 1;
                  else if (kv) begin ld = 1; m_cnt = 1; m_st = MEntry; end
          MEntry: if (cancel) begin tc = 1; m_cnt = 0; m_st = MIdle; end
                  else if (start) m_st = MRun;
                  else if (kv) begin
                    if (m_cnt < MAXD) begin ld = 1; m_cnt++; end
                    else er = 1;
                  end
          MRun:   if (zero) m_st = MDone;
                  else if (cancel) m_st = MPause;
          MPause: if (cancel) begin tc = 1; m_cnt = 0; m_st = MIdle; end
                  else if (start) m_st = MRun;
          MDone:  if (kv || start || cancel) begin tc = 1; m_cnt = 0; m_st = MIdle; end
          default: ;
        endcase
        m_en = (m_st == MRun);
        if (ld) begin m_data = m_pbcd; exp_q.push_back('{0, m_pbcd}); end
        if (tc) exp_q.push_back('{1, 0});
        if (er) exp_q.push_back('{2, 0});

        // key accepted once it has been seen D+1 samples in a row
        if (keys == m_last) begin
          if (m_run < D + 2) m_run++;
        end else begin
          m_run = 1;
          m_last = keys;
        end
        m_pend = 0;
        if (m_run == D + 1) begin
          if (keys == 0) m_armed = 1;
          else if ($countones(keys) > 1) begin m_pend = 2; m_armed = 0; end
          else if (m_armed) begin
            m_pend = 1;
            m_armed = 0;
            for (int i = 0; i < 10; i++) if (keys[i]) m_pbcd = i;
          end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (m_ready) begin
        bit xl, xt, xe;
        int xd;
        xl = 0; xt = 0; xe = 0; xd = 0;
        while (exp_q.size() > 0) begin
          ev_t e;
          e = exp_q.pop_front();
          if (e.kind == 0) begin xl = 1; xd = e.val; end
          else if (e.kind == 1) xt = 1;
          else xe = 1;
        end
        check("loadn", 32'(loadn), 32'(!xl));
        check("tclrn", 32'(tclrn), 32'(!xt));
        check("err", 32'(err), 32'(xe));
        if (xl) check("load_data", 32'(data), 32'(xd));
        check("data", 32'(data), 32'(m_data));
        check("en", 32'(en), 32'(m_en));
        check("digit_cnt", 32'(digit_cnt), 32'(m_cnt));
        if (loadn === 1'b0 || tclrn === 1'b0)
          check("strobe_overlap", 32'(loadn | tclrn), 32'd1);
        if (loadn === 1'b0) n_loads++;
        if (err === 1'b1) n_errs++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int k);
    keys = 10'(1) << k;
    step(8);
    keys = '0;
    step(8);
  endtask

  task automatic pulse_start();
    start = 1; step(1); start = 0;
  endtask

  task automatic pulse_cancel();
    cancel = 1; step(1); cancel = 0; step(2);
  endtask

  int base_l, base_e;

  initial begin
    clr = 1; keys = '0; start = 0; cancel = 0; zero = 0;
    step(2);
    clr = 0;
    step(1);
    check("reset_digit_cnt", 32'(digit_cnt), 32'd0);
    check("reset_loadn", 32'(loadn), 32'd1);

    // two digits, 9 then 8
    base_l = n_loads;
    press(9);
    press(8);
    check("t1_loads", 32'(n_loads - base_l), 32'd2);
    check("t1_digit_cnt", 32'(digit_cnt), 32'd2);
    check("t1_data", 32'(data), 32'd8);
    pulse_cancel();

    // bouncing key 0, then a hold without a stable release in between
    base_l = n_loads;
    for (int i = 0; i < 10; i++) begin keys = 10'(i % 2); step(1); end
    keys = 10'd1; step(8);
    keys = '0; step(2);
    keys = 10'd1; step(8);
    keys = '0; step(8);
    check("t2_loads", 32'(n_loads - base_l), 32'd1);
    check("t2_data", 32'(data), 32'd0);
    pulse_cancel();

    // overflow on the fourth digit
    base_l = n_loads; base_e = n_errs;
    press(1); press(2); press(3); press(4);
    check("t3_loads", 32'(n_loads - base_l), 32'd3);
    check("t3_errs", 32'(n_errs - base_e), 32'd1);
    check("t3_digit_cnt", 32'(digit_cnt), 32'd3);
    pulse_cancel();

    // chord rejected, then key 5 accepted
    base_l = n_loads; base_e = n_errs;
    keys = 10'b0000010100; step(8);
    keys = '0; step(8);
    check("t4_chord_loads", 32'(n_loads - base_l), 32'd0);
    check("t4_chord_errs", 32'(n_errs - base_e), 32'd1);
    press(5);
    check("t4_data", 32'(data), 32'd5);
    pulse_cancel();

    // full cook cycle
    press(1); press(0);
    pulse_start();
    step(20);
    check("t5_en_run", 32'(en), 32'd1);
    zero = 1; step(1); zero = 0; step(2);
    check("t5_en_done", 32'(en), 32'd0);
    pulse_cancel();
    check("t5_digit_cnt", 32'(digit_cnt), 32'd0);

    // run / pause / simultaneous start+cancel / mid-run reset
    press(5);
    pulse_start(); step(3);
    cancel = 1; step(1); cancel = 0; step(2);
    check("t6_pause_en", 32'(en), 32'd0);
    pulse_start(); step(2);
    check("t6_resume_en", 32'(en), 32'd1);
    start = 1; cancel = 1; step(1); start = 0; cancel = 0; step(2);
    check("t6_both_en", 32'(en), 32'd0);
    pulse_start(); step(2);
    clr = 1; step(1); clr = 0;
    check("t6_clr_en", 32'(en), 32'd0);
    check("t6_clr_cnt", 32'(digit_cnt), 32'd0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(5) == 0) begin
        int r;
        r = $urandom_range(9);
        if (r < 5) keys = '0;
        else if (r < 9) keys = 10'(1) << $urandom_range(9);
        else keys = 10'($urandom);
      end
      start  = ($urandom_range(19) == 0);
      cancel = ($urandom_range(29) == 0);
      zero   = ($urandom_range(14) == 0);
      clr    = ($urandom_range(699) == 0);
      step(1);
    end
    clr = 0; start = 0; cancel = 0; zero = 0; keys = '0;
    step(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
